// File: rtl/updown_step_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_step_counter_pkg
// Shared definitions for the up/down step counter and its adder/subtractor.
//   DEFAULT_WIDTH : default counter/step width in bits
//   BOUND_ONE/ZERO: bit values replicated to form the saturation bounds
//   mode_e        : overflow handling mode (MODE_SAT = 1, MODE_WRAP = 0)
// -----------------------------------------------------------------------------
package updown_step_counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Bounds are built by replication so they scale with any WIDTH:
    // all ones is the upper saturation bound, all zeros the lower one.
    localparam logic BOUND_ONE  = 1'b1;
    localparam logic BOUND_ZERO = 1'b0;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage : updown_step_counter_pkg

// File: rtl/addsub_nb.sv
// -----------------------------------------------------------------------------
// addsub_nb
// Combinational WIDTH-bit adder/subtractor. Subtraction is a + ~b + 1, i.e.
// b is inverted and the carry-in is driven high when sub = 1.
//   a, b   : input  WIDTH  operands (unsigned)
//   sub    : input  1      0 = a + b, 1 = a - b
//   s      : output WIDTH  result modulo 2^WIDTH
//   cout   : output 1      adder carry out
//   borrow : output 1      unsigned borrow (sub & ~cout)
// -----------------------------------------------------------------------------
module addsub_nb
    import updown_step_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             borrow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    assign b_eff   = sub ? ~b : b;
    // The carry-in supplies the +1 of the two's-complement negation.
    assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign s      = sum_ext[WIDTH-1:0];
    assign cout   = sum_ext[WIDTH];
    // For subtraction a carry out means "no borrow"; step = 0 thus never borrows.
    assign borrow = sub & ~sum_ext[WIDTH];

endmodule : addsub_nb

// File: rtl/updown_step_counter.sv
// -----------------------------------------------------------------------------
// updown_step_counter
// Registered up/down counter with programmable step, synchronous load and
// wrap or saturate behaviour, plus registered carry/borrow pulses and a
// sticky overflow flag.
//   clk        : input  1      rising-edge clock
//   rst        : input  1      asynchronous, active-high reset
//   en         : input  1      count enable, one step per cycle
//   load       : input  1      synchronous load of load_val, overrides en
//   load_val   : input  WIDTH  value loaded into q
//   up         : input  1      1 = q + step, 0 = q - step
//   step       : input  WIDTH  unsigned step magnitude
//   sat        : input  1      1 = saturate at bounds, 0 = wrap
//   q          : output WIDTH  counter value
//   carry      : output 1      one-cycle pulse after an overflowing up step
//   borrow     : output 1      one-cycle pulse after an underflowing down step
//   ovf_sticky : output 1      set by carry/borrow, cleared by load or rst
//   zero       : output 1      combinational q == 0
// -----------------------------------------------------------------------------
module updown_step_counter
    import updown_step_counter_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             borrow,
    output logic             ovf_sticky,
    output logic             zero
);

    localparam logic [WIDTH-1:0] Q_MAX = {WIDTH{BOUND_ONE}};
    localparam logic [WIDTH-1:0] Q_MIN = {WIDTH{BOUND_ZERO}};

    logic [WIDTH-1:0] sum;
    logic             add_cout;
    logic             sub_borrow;
    mode_e            mode;

    logic [WIDTH-1:0] q_next;
    logic             carry_next;
    logic             borrow_next;
    logic             ovf_next;

    assign mode = mode_e'(sat);

    // A single adder serves both directions; its carry out is only meaningful
    // as an overflow when counting up, and its borrow only when counting down.
    addsub_nb #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a      (q),
        .b      (step),
        .sub    (~up),
        .s      (sum),
        .cout   (add_cout),
        .borrow (sub_borrow)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        q_next      = q;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        ovf_next    = ovf_sticky;

        if (load) begin
            // Load wins over a simultaneous count event, including the sticky flag.
            q_next   = load_val;
            ovf_next = 1'b0;
        end else if (en) begin
            if (up) begin
                carry_next = add_cout;
                q_next     = (add_cout && mode == MODE_SAT) ? Q_MAX : sum;
            end else begin
                borrow_next = sub_borrow;
                q_next      = (sub_borrow && mode == MODE_SAT) ? Q_MIN : sum;
            end
            ovf_next = ovf_sticky | carry_next | borrow_next;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= RESET_VAL;
            carry      <= 1'b0;
            borrow     <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            q          <= q_next;
            carry      <= carry_next;
            borrow     <= borrow_next;
            ovf_sticky <= ovf_next;
        end
    end

    assign zero = (q == Q_MIN);

endmodule : updown_step_counter

// File: tb/tb_updown_step_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_step_counter
// Self-checking bench for updown_step_counter (WIDTH = 8, RESET_VAL = 0).
// Directed scenarios followed by random stimulus, all compared against an
// integer-arithmetic reference model of the counter's behaviour.
// -----------------------------------------------------------------------------
module tb_updown_step_counter;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         up;
    logic [W-1:0] step;
    logic         sat;
    logic [W-1:0] q;
    logic         carry;
    logic         borrow;
    logic         ovf_sticky;
    logic         zero;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int   m_q;
    logic m_carry;
    logic m_borrow;
    logic m_ovf;

    updown_step_counter #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .up         (up),
        .step       (step),
        .sat        (sat),
        .q          (q),
        .carry      (carry),
        .borrow     (borrow),
        .ovf_sticky (ovf_sticky),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},      32'(q),          32'(m_q));
        check({tag, ".carry"},  32'(carry),      32'(m_carry));
        check({tag, ".borrow"}, 32'(borrow),     32'(m_borrow));
        check({tag, ".ovf"},    32'(ovf_sticky), 32'(m_ovf));
        check({tag, ".zero"},   32'(zero),       32'(m_q == 0));
    endtask

    task automatic model_reset();
        m_q      = 0;
        m_carry  = 1'b0;
        m_borrow = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Behaviour derived from the counting rules with plain integer arithmetic.
    task automatic model_edge();
        int v;
        if (rst) begin
            model_reset();
        end else if (load) begin
            m_q      = int'(load_val);
            m_carry  = 1'b0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else if (en) begin
            m_carry  = 1'b0;
            m_borrow = 1'b0;
            if (up) begin
                v = m_q + int'(step);
                if (v > MAXV) begin
                    m_carry = 1'b1;
                    v = sat ? MAXV : v - (MAXV + 1);
                end
            end else begin
                v = m_q - int'(step);
                if (v < 0) begin
                    m_borrow = 1'b1;
                    v = sat ? 0 : v + (MAXV + 1);
                end
            end
            m_q   = v;
            m_ovf = m_ovf | m_carry | m_borrow;
        end else begin
            m_carry  = 1'b0;
            m_borrow = 1'b0;
        end
    endtask

    // One clock: model the edge with the current inputs, then sample outputs
    // 1 time unit after the rising edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic i_en, input logic i_load, input logic [W-1:0] i_lv,
                          input logic i_up, input logic [W-1:0] i_step, input logic i_sat);
        en       = i_en;
        load     = i_load;
        load_val = i_lv;
        up       = i_up;
        step     = i_step;
        sat      = i_sat;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b0;

        // Load then wrap down
        set_in(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
        tick("load05");
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 6; i++) tick($sformatf("wrapdown%0d", i));
        check("wrapdown_final_q", 32'(q), 32'h0000_00FF);
        check("wrapdown_final_borrow", 32'(borrow), 32'h1);
        check("wrapdown_final_ovf", 32'(ovf_sticky), 32'h1);

        // Saturating down
        set_in(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        tick("load03");
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1);
        tick("satdown0");
        tick("satdown1");
        check("satdown_q", 32'(q), 32'h0);
        check("satdown_borrow", 32'(borrow), 32'h1);

        // Wrap up, then saturate up
        set_in(1'b0, 1'b1, 8'hFE, 1'b1, 8'h00, 1'b0);
        tick("loadFE_a");
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
        tick("wrapup");
        check("wrapup_q", 32'(q), 32'h01);
        check("wrapup_carry", 32'(carry), 32'h1);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0);
        tick("carry_drop");
        set_in(1'b0, 1'b1, 8'hFE, 1'b1, 8'h00, 1'b1);
        tick("loadFE_b");
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1);
        tick("satup");
        check("satup_q", 32'(q), 32'hFF);
        check("satup_carry", 32'(carry), 32'h1);

        // Load/en collision clears sticky flag
        check("collision_pre_ovf", 32'(ovf_sticky), 32'h1);
        set_in(1'b1, 1'b1, 8'h40, 1'b1, 8'h03, 1'b0);
        tick("collision");
        check("collision_q", 32'(q), 32'h40);
        check("collision_ovf", 32'(ovf_sticky), 32'h0);

        // step = 0 and hold
        set_in(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        tick("load00");
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick("step0_down");
        check("step0_borrow", 32'(borrow), 32'h0);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
        for (int i = 0; i < 3; i++) tick($sformatf("hold%0d", i));

        // Asynchronous reset mid-count
        set_in(1'b0, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0);
        tick("load10");
        set_in(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0);
        tick("countup0");
        tick("countup1");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_q", 32'(q), 32'h0);
        tick("rst_held");
        rst = 1'b0;
        tick("resume0");
        check("resume_q", 32'(q), 32'h02);
        tick("resume1");

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] rs;
            case ($urandom_range(3))
                0:       rs = 8'h00;
                1:       rs = 8'(($urandom_range(7)));
                2:       rs = 8'(($urandom_range(255, 200)));
                default: rs = 8'($urandom);
            endcase
            set_in(($urandom_range(3) != 0), ($urandom_range(7) == 0), 8'($urandom),
                   1'($urandom), rs, 1'($urandom));
            tick($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_updown_step_counter

// File: doc/updown_step_counter.md
# updown_step_counter

Parametrised, registered up/down counter with programmable step, synchronous load, and selectable wrap or saturate behaviour. It is the sequential successor of the team's 8-bit combinational decrementer. It generalises width, direction and step size, and adds a registered carry/borrow pulse and a sticky overflow flag. It sits wherever datapath blocks need a loadable countdown or countup register, such as timers, loop counters and address generators.

## Interface
Parameters:
- WIDTH, 8, counter and step width in bits (≥ 2)
- RESET_VAL, 0, value of q after reset (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable (one step per cycle while high)
- load  input  1  synchronous load of load_val; overrides en
- load_val  input  WIDTH  value loaded into q
- up  input  1  direction: 1 = q + step, 0 = q − step
- step  input  WIDTH  step magnitude, unsigned
- sat  input  1  1 = saturate at bounds, 0 = wrap modulo 2^WIDTH
- q  output  WIDTH  counter value, registered
- carry  output  1  registered; high for the cycle after an up step overflowed
- borrow  output  1  registered; high for the cycle after a down step underflowed
- ovf_sticky  output  1  registered; set by any carry or borrow event, cleared by load
- zero  output  1  combinational, q == 0

## Operation
- **Reset:** q = RESET_VAL, carry = 0, borrow = 0, ovf_sticky = 0.
- **Priority per cycle:** rst, then load, then en, then hold.
- **Load:**
  - q ← load_val.
  - carry = borrow = 0.
  - ovf_sticky ← 0.
- **Up step** (en & !load & up):
  - sum = {1'b0,q} + {1'b0,step}, WIDTH+1 bits; c = sum[WIDTH].
  - If c = 0: q ← sum[WIDTH−1:0].
  - If c = 1 and sat = 0: q ← sum[WIDTH−1:0].
  - If c = 1 and sat = 1: q ← all ones.
  - carry ← c, borrow ← 0.
- **Down step** (en & !load & !up):
  - Computed as q + ~step + 1 through the adder; b = ~cout (unsigned borrow).
  - If b = 0: q ← difference.
  - If b = 1 and sat = 0: q ← difference (wraps).
  - If b = 1 and sat = 1: q ← 0.
  - borrow ← b, carry ← 0.
- **step = 0:** q is unchanged; carry = borrow = 0. A down step of 0 produces cout = 1, so no borrow.
- **Hold** (no en, no load): q unchanged; carry = borrow = 0.
- **Event pulses:** carry and borrow are single-cycle per event. Consecutive overflowing steps give consecutive high cycles.
- **ovf_sticky:** set when carry or borrow is set, and stays set until load or rst. If load and an event occur in the same cycle, the load wins.
- **Mid-operation:** sat, up and step may change every cycle. Only the values sampled at the active edge matter.
- **Reset mid-count:** takes effect immediately (asynchronous) regardless of en or load.

## Timing
- Latency is one cycle: inputs sampled at rising edge N give q, carry, borrow and ovf_sticky valid after edge N.
- zero follows q combinationally in the same cycle.
- No handshake. en may be held high indefinitely for one step per cycle.
- rst is asynchronous on assertion. Deassertion must be synchronous to clk; this is guaranteed by the system reset synchroniser.
- Single combinational path per cycle: one WIDTH-bit adder plus the saturation mux.

## Structure
- The shared package holds:
  - the WIDTH default;
  - localparams for all-ones and all-zeros bounds;
  - the mode encoding (SAT = 1, WRAP = 0).
- One sub-module, addsub_nb: parametrised WIDTH combinational adder/subtractor.
  - Inputs: a, b, sub.
  - Outputs: s, cout, borrow.
  - Internally it inverts b and drives Cin = 1 when sub = 1, the same method the team already uses for the fixed 8-bit decrementer.
- The top level contains:
  - the q/flag registers;
  - the priority and saturation muxing;
  - the sticky flag.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=0.
- **Load then wrap down:** load 0x05; then en=1, up=0, step=1, sat=0 for 6 cycles. Required: q = 04, 03, 02, 01, 00, FF; borrow high only in the cycle q=FF; zero high when q=00; ovf_sticky high from the FF cycle.
- **Saturating down:** load 0x03; down, step=5, sat=1 for 2 cycles. Required: q = 00 then 00; borrow high both cycles.
- **Wrap and saturate up:**
  - Load 0xFE; up, step=3, sat=0. Required: q = 0x01, carry = 1 for one cycle.
  - Repeat with sat=1. Required: q = 0xFF, carry = 1.
- **Load/en collision and sticky clear:**
  - Create a carry event so ovf_sticky = 1.
  - Next cycle assert load=1, en=1, load_val=0x40. Required: q = 0x40, carry = borrow = 0, ovf_sticky = 0.
- **step=0 and hold:**
  - q=0x00, en=1, down, step=0. Required: q stays 0x00, borrow = 0.
  - en=0 for 3 cycles. Required: q unchanged, flags 0.
- **Asynchronous reset mid-count:** count up from 0x10 with step 2. Assert rst between clock edges. Required: q = 0x00 and all flags 0 immediately (before the next edge), held while rst is high; counting resumes from 0x00 after release.
